bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter from unsigned binary to packed BCD.
- Sits between the Fibonacci term generator and the 7-segment display controller.
- Turns the 14-bit binary term into four decimal digits the display can show directly.
- Uses one bit per clock to keep area small. Output is held stable between conversions so the multiplexed display never sees partial values.

Parameters:
- WIDTH, 14, width of binary input. Requires 2^WIDTH < 10^(DIGITS+1).
- DIGITS, 4, number of BCD digits presented on bcd. Internal register holds DIGITS+1 digits.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- bin  input  WIDTH  unsigned binary value to convert
- in_valid  input  1  bin is valid this cycle
- in_ready  output  1  converter idle; a conversion is accepted when in_valid && in_ready at the rising edge
- bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0]; held until the next completion
- out_valid  output  1  one-cycle pulse: bcd was updated this cycle
- ovf  output  1  last converted value exceeded 10^DIGITS-1 (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, sampled on clk):
  - state=IDLE, in_ready=1, bcd=0, out_valid=0, ovf=0, bit counter=0, scratch registers cleared.
  - Reset mid-conversion aborts the conversion: no out_valid, bcd=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture bin into shift register, clear BCD scratch ((DIGITS+1)*4 bits), counter=WIDTH, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, first add 3 to every scratch digit >=5 (all digits in parallel, 4-bit nibble arithmetic, no carry between nibbles).
  - Then shift {scratch, binreg} left by one.
  - Decrement counter; when it reaches 1 on the current shift, go to DONE after this edge. Exactly WIDTH shift cycles in total.
- DONE (one cycle):
  - Register the output: bcd <= low DIGITS digits of scratch (or saturated value under the macro).
  - Update ovf; out_valid=1 for this single cycle; return to IDLE.
- Timing: acceptance at edge 0; shifts at edges 1..WIDTH; bcd/out_valid update at edge WIDTH+1. With default WIDTH: 15 cycles acceptance-to-result, minimum 16-cycle issue interval.
- in_valid while in_ready=0 is ignored (no queuing); the upstream producer must hold or re-present the value.
- in_ready is high in the cycle where out_valid=1, so back-to-back acceptance is legal. bcd still updates only at the next completion.
- bin is sampled only at acceptance; changes during SHIFT have no effect.
- bcd and ovf never change except at a DONE edge or reset.

Optional Feature:
- Macro: BIN2BCD_SAT_EN.
- Defined:
  - If the fifth (top internal) scratch digit is nonzero at DONE, bcd saturates to all nines (16'h9999 for DIGITS=4) and ovf=1.
  - Otherwise ovf=0 and bcd is the exact conversion.
- Undefined:
  - bcd is always the low DIGITS digits (value mod 10^DIGITS).
  - ovf is tied to 0.
  - Saturation/compare logic is not compiled.

Test Plan:
- Reset, then bin=0 with in_valid for 1 cycle -> in_ready drops next cycle; out_valid pulses exactly 15 cycles after acceptance; bcd=16'h0000, ovf=0.
- bin=377 -> bcd=16'h0377. Then bin=6765 -> bcd=16'h6765. bcd stays 16'h0377 throughout the second conversion until its out_valid.
- bin=9999 -> bcd=16'h9999, ovf=0 (with and without macro).
- bin=10946, macro undefined -> bcd=16'h0946, ovf=0. Macro defined -> bcd=16'h9999, ovf=1. Then bin=5 -> bcd=16'h0005, ovf=0.
- Accept bin=144, then toggle in_valid with bin=233 during SHIFT -> ignored, single out_valid with bcd=16'h0144. Then present bin=233 with in_valid held from the out_valid cycle -> accepted that edge; bcd=16'h0233 16 cycles after the first completion.
- Accept bin=987, assert reset at shift cycle 7 for 1 cycle -> no out_valid; bcd=0, ovf=0, in_ready=1 the cycle after reset. A fresh bin=987 then yields bcd=16'h0987.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: WIDTH-bit unsigned binary to DIGITS packed BCD digits, one bit per clock.
// Optional saturation of out-of-range results is enabled by defining BIN2BCD_SAT_EN.
module bin2bcd_seq #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      bin,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  out_valid,
   output logic                  ovf
);

   localparam int SW = (DIGITS + 1) * 4;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    bin_q, bin_d;
   logic [SW-1:0]       scratch_q, scratch_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                ovf_q, ovf_d;
   logic                out_valid_q, out_valid_d;
   logic                in_ready_q, in_ready_d;
   logic [SW-1:0]       scratch_adj_s;

   // Nibble-wise add-3 correction; digits never carry into each other.
   function automatic logic [SW-1:0] add3_all(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (s[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = s[4*i +: 4];
         end
      end
      return r;
   endfunction

   assign scratch_adj_s = add3_all(scratch_q);

   // State register and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bin_q       <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next-state and datapath logic; bcd/ovf only move when leaving DONE.
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      bcd_d       = bcd_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               bin_d     = bin;
               scratch_d = '0;
               cnt_d     = CW'(WIDTH);
               state_d   = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            scratch_d = {scratch_adj_s[SW-2:0], bin_q[WIDTH-1]};
            bin_d     = {bin_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
`ifdef BIN2BCD_SAT_EN
            if (scratch_q[SW-1 -: 4] != 4'd0) begin
               bcd_d = {DIGITS{4'h9}};
               ovf_d = 1'b1;
            end else begin
               bcd_d = scratch_q[4*DIGITS-1:0];
               ovf_d = 1'b0;
            end
`else
            bcd_d = scratch_q[4*DIGITS-1:0];
            ovf_d = 1'b0;
`endif
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   assign in_ready  = in_ready_q;
   assign bcd       = bcd_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected digits from an arithmetic decimal model, checked at each out_valid.
module tb_bin2bcd_seq;

   localparam int W = 14;
   localparam int D = 4;
   localparam int LAT = W + 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [W-1:0]   bin = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [4*D-1:0] bcd;
   logic           out_valid;
   logic           ovf;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        rst_at_edge = 1'b1;
   logic [15:0] bcd_prev = 16'h0000;
   logic        ovf_prev = 1'b0;

   bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk(clk), .reset(reset), .bin(bin), .in_valid(in_valid),
      .in_ready(in_ready), .bcd(bcd), .out_valid(out_valid), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void model(input int v, output logic [15:0] b, output logic o);
      int t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         b[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      o = 1'b0;
`ifdef BIN2BCD_SAT_EN
      if (v > 9999) begin
         b = 16'h9999;
         o = 1'b1;
      end
`endif
   endfunction

   // Push expectations on accepted handshakes; reset discards in-flight work.
   always @(posedge clk) begin
      exp_t e;
      if (reset) begin
         sb.delete();
      end else if (in_valid && in_ready) begin
         model(int'(bin), e.bcd, e.ovf);
         e.due = cyc + 1 + LAT;
         sb.push_back(e);
      end
      rst_at_edge <= reset;
      cyc <= cyc + 1;
   end

   // Compare on out_valid; otherwise bcd/ovf must hold.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         if (sb.size() == 0) begin
            check_value("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check_value("bcd", 32'(bcd), 32'(e.bcd));
            check_value("ovf", 32'(ovf), 32'(e.ovf));
            check_value("latency", 32'(cyc), 32'(e.due));
         end
      end else if (!rst_at_edge) begin
         check_value("bcd_hold", 32'(bcd), 32'(bcd_prev));
         check_value("ovf_hold", 32'(ovf), 32'(ovf_prev));
      end
      bcd_prev = bcd;
      ovf_prev = ovf;
   end

   task automatic wait_ready();
      int i;
      for (i = 0; i < 100; i++) begin
         if (in_ready) break;
         @(posedge clk); #1;
      end
      if (i == 100) check_value("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input int v);
      wait_ready();
      bin = W'(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_value("ready_drop", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (out_valid) break;
      end
      if (i == 100) check_value("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int vals[7] = '{0, 377, 6765, 9999, 10946, 5, 144};
      int i;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_value("rst_in_ready", 32'(in_ready), 32'd1);
      check_value("rst_bcd", 32'(bcd), 32'd0);
      check_value("rst_out_valid", 32'(out_valid), 32'd0);
      check_value("rst_ovf", 32'(ovf), 32'd0);

      for (int k = 0; k < 6; k++) begin
         send(vals[k]);
         wait_done();
      end

      // 144, with a competing request toggled during its shifts.
      send(vals[6]);
      repeat (3) begin
         bin = 14'd233;
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      for (i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      if (i == 100) check_value("done_timeout", 32'd0, 32'd1);
      bin = 14'd233;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_value("b2b_accept", 32'(in_ready), 32'd0);
      wait_done();

      // Abort 987 mid-conversion.
      send(987);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_value("abort_in_ready", 32'(in_ready), 32'd1);
      check_value("abort_bcd", 32'(bcd), 32'd0);
      check_value("abort_ovf", 32'(ovf), 32'd0);
      check_value("abort_out_valid", 32'(out_valid), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      send(987);
      wait_done();
      repeat (3) @(posedge clk);
      #1;
      check_value("sb_drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
